// File: rtl/reset_seq_pkg.sv
// Shared types and elaboration helpers for the boot reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        ST_POR   = 2'd0,
        ST_DUMMY = 2'd1,
        ST_HOLD  = 2'd2,
        ST_RUN   = 2'd3
    } seq_state_t;

    function automatic int cnt_width(
        input int por,
        input int dummy,
        input int div,
        input int hold
    );
        int m;
        m = por;
        if (dummy * div > m) m = dummy * div;
        if (hold > m) m = hold;
        return $clog2(m + 1);
    endfunction

    function automatic bit dummy_edges_ok(input int n);
        return (n >= 2) && ((n % 2) == 0);
    endfunction

endpackage

// File: rtl/cclk_toggle_gen.sv
// Divider producing one toggle strobe per CLK_DIV enabled cycles.
module cclk_toggle_gen #(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic toggle
);

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign toggle = en && (div_cnt == '0);

    // Held at the reload value while idle so each DUMMY phase starts aligned.
    always_ff @(posedge clk) begin
        if (rst || !en || toggle) begin
            div_cnt <= DIV_LOAD;
        end else begin
            div_cnt <= div_cnt - DW'(1);
        end
    end

endmodule

// File: rtl/boot_reset_sequencer.sv
// POR, CCLK dummy-edge and reset-hold sequencer driving sys_rst.
module boot_reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int POR_CYCLES  = 15,
    parameter int DUMMY_EDGES = 6,
    parameter int CLK_DIV     = 1,
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_REQ     = 2,
    parameter int REDUMMY     = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               cclk_val_in,
    input  logic               cclk_drive_in,
    output logic               sys_rst,
    output logic               cclk_o,
    output logic               cclk_ts,
    output logic               ready,
    output logic [1:0]         state,
    output logic [NUM_REQ-1:0] reset_cause
);

    localparam int DUMMY_LEN = DUMMY_EDGES * CLK_DIV;
    localparam int CW = cnt_width(POR_CYCLES, DUMMY_EDGES, CLK_DIV, HOLD_CYCLES);
    localparam logic [CW-1:0] POR_LOAD   = CW'(POR_CYCLES);
    localparam logic [CW-1:0] DUMMY_LOAD = CW'(DUMMY_LEN - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

    if (!dummy_edges_ok(DUMMY_EDGES)) begin : g_bad_dummy
        $error("DUMMY_EDGES must be even and at least 2");
    end

    seq_state_t         st_q;
    seq_state_t         st_d;
    logic [CW-1:0]      cnt_q;
    logic [CW-1:0]      cnt_d;
    logic [NUM_REQ-1:0] cause_d;
    logic               sys_rst_d;
    logic               cclk_o_d;
    logic               cclk_ts_d;
    logic               ready_d;
    logic               toggle;
    logic               any_req;
    logic               cnt_zero;

    cclk_toggle_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_toggle (
        .clk    (clk),
        .rst    (rst),
        .en     (st_q == ST_DUMMY),
        .toggle (toggle)
    );

    assign any_req  = |req;
    assign cnt_zero = (cnt_q == '0);
    assign state    = st_q;

    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q - CW'(1);
        cause_d = reset_cause;
        unique case (st_q)
            ST_POR: begin
                if (cnt_zero) begin
                    st_d  = ST_DUMMY;
                    cnt_d = DUMMY_LOAD;
                end
            end
            ST_DUMMY: begin
                if (cnt_zero) begin
                    st_d  = ST_HOLD;
                    cnt_d = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (any_req) begin
                    cnt_d = HOLD_LOAD;
                end else if (cnt_zero) begin
                    st_d  = ST_RUN;
                    cnt_d = HOLD_LOAD;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q;
                if (any_req) begin
                    cause_d = req;
                    st_d    = (REDUMMY != 0) ? ST_DUMMY : ST_HOLD;
                    cnt_d   = (REDUMMY != 0) ? DUMMY_LOAD : HOLD_LOAD;
                end
            end
            default: ;
        endcase
    end

    // Outputs follow the next state so they register together with it.
    always_comb begin
        sys_rst_d = 1'b1;
        ready_d   = 1'b0;
        cclk_ts_d = 1'b1;
        cclk_o_d  = 1'b1;
        unique case (st_d)
            ST_RUN: begin
                sys_rst_d = 1'b0;
                ready_d   = 1'b1;
                cclk_o_d  = cclk_val_in;
                cclk_ts_d = ~cclk_drive_in;
            end
            ST_DUMMY: begin
                if (st_q == ST_DUMMY) begin
                    cclk_o_d = toggle ? ~cclk_o : cclk_o;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= ST_POR;
            cnt_q       <= POR_LOAD;
            sys_rst     <= 1'b1;
            cclk_o      <= 1'b1;
            cclk_ts     <= 1'b1;
            ready       <= 1'b0;
            reset_cause <= '0;
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            sys_rst     <= sys_rst_d;
            cclk_o      <= cclk_o_d;
            cclk_ts     <= cclk_ts_d;
            ready       <= ready_d;
            reset_cause <= cause_d;
        end
    end

endmodule

// File: doc/boot_reset_sequencer.md
Name: boot_reset_sequencer

Overview:
Parametrised power-on reset and configuration-clock handoff sequencer for board top levels. It generalises the fixed boot-reset counter and the 3-cycle CCLK dummy-toggle workaround into one block with:
- configurable POR length, dummy-edge count, clock divider and post-reset hold;
- multiple reset-request sources with reset-cause capture.

It sits between the STARTUPE2 CCLK pins, the tester core's reset requests and the global sys_rst net.

Parameters:
POR_CYCLES, 15, cycles held in POR after rst release (>=1)
DUMMY_EDGES, 6, CCLK toggles emitted before handoff (even, >=2; elaboration error otherwise)
CLK_DIV, 1, clk cycles per CCLK toggle (>=1)
HOLD_CYCLES, 4, minimum sys_rst stretch after dummy phase or reset request (>=1)
NUM_REQ, 2, number of reset-request inputs (>=1)
REDUMMY, 0, 1 = reset request re-runs DUMMY before HOLD; 0 = goes straight to HOLD

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high; restarts whole sequence from POR
req  input  NUM_REQ  level reset requests (e.g. reset_req from tester core)
cclk_val_in  input  1  user CCLK value from SPI master
cclk_drive_in  input  1  user CCLK drive enable, active high
sys_rst  output  1  registered global reset to rest of design
cclk_o  output  1  registered to STARTUPE2 USRCCLKO
cclk_ts  output  1  registered to STARTUPE2 USRCCLKTS (1 = high-z)
ready  output  1  high only in RUN
state  output  2  current state encoding
reset_cause  output  NUM_REQ  req bits sampled on last RUN exit

Behaviour:
- Clock and reset: clk, with reset rst, synchronous, active-high. All outputs registered.
- Reset values while rst=1: state=POR, sys_rst=1, cclk_o=1, cclk_ts=1, ready=0, reset_cause=0, counters loaded.
- t0 = first clk edge sampling rst=0.
- POR:
  - Lasts exactly POR_CYCLES cycles; req ignored.
  - cclk_ts=1, cclk_o=1.
  - Then DUMMY.
- DUMMY:
  - Lasts DUMMY_EDGES*CLK_DIV cycles; cclk_ts=1.
  - cclk_o toggles on the last cycle of each CLK_DIV period, so it ends at 1.
  - State moves to HOLD on the edge of the final toggle; req ignored.
- HOLD:
  - Lasts HOLD_CYCLES cycles with sys_rst=1, cclk_ts=1, cclk_o=1.
  - Any req bit high reloads the counter, so HOLD ends HOLD_CYCLES cycles after req is last seen high.
  - Then RUN.
- RUN:
  - sys_rst=0, ready=1.
  - cclk_o<=cclk_val_in and cclk_ts<=~cclk_drive_in, with 1-cycle latency.
- Reset request in RUN: |req=1 at an edge means next cycle state=HOLD (REDUMMY=0) or DUMMY (REDUMMY=1), with:
  - sys_rst=1, ready=0, cclk_ts=1, cclk_o=1;
  - reset_cause<=req.
- Latency:
  - From t0, sys_rst deasserts after POR_CYCLES+DUMMY_EDGES*CLK_DIV+HOLD_CYCLES cycles (defaults: 25).
  - From a RUN req pulse, sys_rst asserts 1 cycle later.
- Precedence: rst at any time, including mid-DUMMY or mid-HOLD, overrides everything and restarts POR; reset_cause is cleared.
- req while rst=1: ignored.
- Counters:
  - Single down-counter, width $clog2(max(POR_CYCLES, DUMMY_EDGES*CLK_DIV, HOLD_CYCLES)+1).
  - Separate divider counter of width $clog2(CLK_DIV+1).
  - No wrap: a counter at 0 triggers the transition and is reloaded for the next state.
- The state output uses the package encoding: POR=0, DUMMY=1, HOLD=2, RUN=3.

Decomposition:
- Package reset_seq_pkg holds:
  - state typedef/encoding (2 bits);
  - localparam function for counter width;
  - DUMMY_EDGES parity check helper.
- One sub-module is natural: cclk_toggle_gen. It takes en and CLK_DIV, outputs a toggle strobe, and owns the divider counter.
- The FSM and output registers stay in boot_reset_sequencer.

Test Plan:
1. Defaults, rst high 3 cycles then low -> sys_rst=1 for exactly 25 cycles from t0; cclk_o shows 6 toggles at cycles t0+15..t0+20 ending at 1; ready=1 at t0+25.
2. CLK_DIV=3, DUMMY_EDGES=4 -> cclk_o period 6 clk cycles, 4 toggles, cclk_ts=1 throughout until RUN.
3. In RUN, cclk_drive_in=1 with cclk_val_in pattern 1,0,1,1 -> cclk_o reproduces the pattern 1 cycle later; cclk_ts=0.
4. In RUN, req=2'b10 for 1 cycle -> sys_rst=1 next cycle, reset_cause=2'b10, RUN re-entered after 4 cycles; req held 10 cycles -> RUN 4 cycles after req falls.
5. REDUMMY=1, req=2'b01 in RUN -> 6 fresh cclk_o toggles, then HOLD 4, then RUN; reset_cause=2'b01.
6. rst asserted mid-DUMMY (after 3 toggles) -> next cycle state=POR, cclk_o=1, reset_cause=0; full 25-cycle sequence repeats.
